// File: rtl/shift_denorm_if.sv
// rtl/shift_denorm_if.sv - request/response handshake bundle for shift_denorm
interface shift_denorm_if #(
  parameter int W = 22
);
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_data;
  logic [4:0]   i_shift;
  logic         i_dir;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic         o_ovf;

  modport slave (
    input  i_valid, i_data, i_shift, i_dir, i_ready,
    output o_ready, o_valid, o_data, o_ovf
  );

  modport master (
    output i_valid, i_data, i_shift, i_dir, i_ready,
    input  o_ready, o_valid, o_data, o_ovf
  );
endinterface

// File: rtl/shift_denorm.sv
// rtl/shift_denorm.sv - multi-cycle signed fixed-point shifter, up to STEP bits per cycle
// Right shifts are arithmetic; left shifts saturate on overflow.
module shift_denorm #(
  parameter int QM   = 11,
  parameter int QN   = 11,
  parameter int STEP = 4
) (
  input  logic           clk,
  input  logic           reset,
  shift_denorm_if.slave  bus
);
  localparam int W  = QM + QN;
  localparam int RW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [RW-1:0] rem_q, rem_d;
  logic          dir_q, dir_d;
  logic          sign_q, sign_d;
  logic          ovf_q, ovf_d;

  logic [RW-1:0] amount;
  logic [RW-1:0] step_amt;
  logic          step_ovf;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    amount   = '0;
    step_amt = rem_q;
    step_ovf = 1'b0;

    if (int'(bus.i_shift) > W) begin
      amount = RW'(W);
    end else begin
      amount = RW'(bus.i_shift);
    end

    if (int'(rem_q) > STEP) begin
      step_amt = RW'(STEP);
    end

    // Left step by s loses information unless the top s+1 bits all match the sign.
    for (int i = 0; i < W - 1; i++) begin
      if ((W - 1 - i) <= int'(step_amt) && data_q[i] != data_q[W-1]) begin
        step_ovf = 1'b1;
      end
    end
    if (int'(step_amt) >= W && data_q != '0) begin
      step_ovf = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          data_d  = bus.i_data;
          dir_d   = bus.i_dir;
          sign_d  = bus.i_data[W-1];
          ovf_d   = 1'b0;
          rem_d   = amount;
          state_d = (amount != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (dir_q) begin
          data_d = data_q << step_amt;
          if (step_ovf) begin
            ovf_d = 1'b1;
          end
        end else begin
          data_d = unsigned'($signed(data_q) >>> step_amt);
        end
        rem_d = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.i_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    bus.o_ready = (state_q == S_IDLE);
    bus.o_valid = (state_q == S_DONE);
    bus.o_data  = '0;
    bus.o_ovf   = 1'b0;
    if (state_q == S_DONE) begin
      bus.o_ovf  = ovf_q;
      bus.o_data = ovf_q ? (sign_q ? SAT_NEG : SAT_POS) : data_q;
    end
  end
endmodule
